projective_to_affine: RTL and testbench
=======================================

// Module: projective_to_affine
// PURPOSE
// Converts a projective Edwards25519 point (X:Y:Z), as produced by the point
// addition stage, back to affine (x,y) = (X/Z, Y/Z) mod p.
// It also emits the 256-bit compressed encoding {x[0], y[254:0]}.
// Z^-1 is computed by Fermat inversion Z^(p-2), using one internal bit-serial
// modular multiplier, so latency is fixed and data-independent.
// Sits between the curve arithmetic core and the key/signature output logic.
// PARAMETERS
// P  256'h7FFF...FFED (2^255-19)  field modulus; fixed, not for override
// EXP  P-2 = 2^255-21  inversion exponent; 255 bits, bits 2 and 4 are zero, all others one
// PORTS
// clk        in   1    clock, all state on rising edge
// rst_n      in   1    asynchronous active-low reset
// in_valid   in   1    X/Y/Z valid
// in_ready   out  1    block idle, can accept
// in_x       in   256  projective X, any value < 2^256
// in_y       in   256  projective Y, any value < 2^256
// in_z       in   256  projective Z, any value < 2^256
// out_valid  out  1    result valid, held until out_ready
// out_ready  in   1    consumer accepts result
// out_x      out  256  affine x in [0,p)
// out_y      out  256  affine y in [0,p)
// out_enc    out  256  {out_x[0], out_y[254:0]}
// out_zzero  out  1    Z reduced to 0 (point at infinity / invalid); outputs are 0
// BEHAVIOUR
// - Reset (async, any time incl. mid-operation): state=IDLE, in_ready=1, out_valid=0,
//   out_x=out_y=out_enc=0, out_zzero=0. Any in-flight conversion is discarded.
// - Accept on the edge where in_valid && in_ready. Operands are reduced at capture
//   by up to two conditional subtractions of P (2^256 < 3P). in_ready drops the next cycle.
// - Multiplier: interleaved MSB-first a*b mod P. Each cycle: acc = 2*acc mod P;
//   if b[i], acc = acc + a mod P. Both operands must be < P; acc is never >= P.
//   One multiply takes exactly 256 cycles (i=255..0).
// - FSM: IDLE -> INV_SQR -> INV_MUL -> MUL_X -> MUL_Y -> DONE.
//   Inversion: r=1; for i=254..0 { r=r*r (INV_SQR); if EXP[i] r=r*Zred (INV_MUL) }.
//   This gives 255 squarings + 253 multiplies = 508 multiplies.
//   MUL_X: out_x=Xred*r. MUL_Y: out_y=Yred*r. The bit index counter wraps 254->0 exactly once.
// - Latency: out_valid first high exactly 510*256+1 = 130561 cycles after the accept edge.
//   State changes cost no extra cycles.
// - DONE: out_valid=1; out_x/out_y/out_enc/out_zzero stable while out_valid && !out_ready.
//   On the out_valid && out_ready edge: state goes to IDLE, out_valid=0, in_ready=1.
//   No input is accepted in the same cycle (one result in flight max).
// - out_zzero=1 when Zred==0; the datapath runs normally and yields x=y=0. Latency is unchanged.
// - in_valid while busy is ignored; the source must hold it until in_ready.
// TESTING
// 1. X=7,Y=9,Z=1 -> after 130561 cycles out_x=7, out_y=9, out_enc[255]=1, out_zzero=0.
// 2. X=2,Y=4,Z=2 -> out_x=1, out_y=2; X=3,Y=5,Z=P-1 -> out_x=P-3, out_y=P-5.
// 3. X=P+5,Y=2P+1,Z=P+1 (unreduced) -> out_x=5, out_y=1.
// 4. Z=0 -> out_zzero=1, out_x=out_y=out_enc=0 at the same latency.
// 5. out_ready=0 for 50 cycles after out_valid -> outputs stable, in_ready=0.
//    Then out_ready=1 -> in_ready=1 next cycle.
// 6. rst_n low at cycle 60000 of a conversion -> all outputs reset immediately.
//    After release, a new X=7,Y=9,Z=1 is accepted and returns 7,9.

Source files
------------

// File: rtl/projective_to_affine.sv
// Projective (X:Y:Z) to affine (x,y) conversion over GF(2^255-19).
// Z^-1 is computed by Fermat inversion using one bit-serial modular multiplier.
module projective_to_affine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_x,
  input  logic [255:0] in_y,
  input  logic [255:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_x,
  output logic [255:0] out_y,
  output logic [255:0] out_enc,
  output logic         out_zzero
);

  localparam logic [255:0] P   = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] EXP = P - 256'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV_SQR,
    S_INV_MUL,
    S_MUL_X,
    S_MUL_Y,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [255:0] r_x;
  logic [255:0] r_y;
  logic [255:0] r_z;
  logic         r_zz;
  logic [255:0] r_r;
  logic [255:0] r_acc;
  logic [7:0]   r_bit;
  logic [7:0]   r_eidx;
  logic         r_oval;
  logic [255:0] r_ox;
  logic [255:0] r_oy;
  logic         r_ozz;

  logic [255:0] w_xred;
  logic [255:0] w_yred;
  logic [255:0] w_zred;
  logic [255:0] w_a;
  logic [255:0] w_b;
  logic         w_bbit;
  logic [256:0] w_d2;
  logic [255:0] w_dbl;
  logic [256:0] w_sum;
  logic [255:0] w_add;
  logic [255:0] w_step;
  logic         w_mend;
  logic         w_ebit;
  logic         w_elast;
  logic         w_busy;
  logic         w_accept;
  logic         w_edec;

  // Inputs are below 2^256 < 3P, so two conditional subtractions suffice.
  function automatic logic [255:0] f_red(input logic [255:0] v);
    return (v >= P) ? v - P : v;
  endfunction

  assign w_xred = f_red(f_red(in_x));
  assign w_yred = f_red(f_red(in_y));
  assign w_zred = f_red(f_red(in_z));

  always_comb begin
    w_a = r_r;
    w_b = r_r;
    case (r_state)
      S_INV_MUL: w_b = r_z;
      S_MUL_X:   w_a = r_x;
      S_MUL_Y:   w_a = r_y;
      default:   ;
    endcase
  end

  // One MSB-first step: acc = 2*acc (+ a) mod P, acc stays in [0,P).
  assign w_bbit = w_b[r_bit];
  assign w_d2   = {r_acc, 1'b0};
  assign w_dbl  = (w_d2 >= {1'b0, P}) ? w_d2[255:0] - P
                                      : w_d2[255:0];
  assign w_sum  = {1'b0, w_dbl} + {1'b0, w_a};
  assign w_add  = (w_sum >= {1'b0, P}) ? w_sum[255:0] - P
                                       : w_sum[255:0];
  assign w_step = w_bbit ? w_add : w_dbl;

  assign w_mend  = (r_bit == 8'd0);
  assign w_ebit  = EXP[r_eidx];
  assign w_elast = (r_eidx == 8'd0);

  assign w_busy = (r_state == S_INV_SQR) ||
                  (r_state == S_INV_MUL) ||
                  (r_state == S_MUL_X)   ||
                  (r_state == S_MUL_Y);

  assign w_accept = (r_state == S_IDLE) && in_valid;

  assign w_edec = w_mend && !w_elast &&
                  (((r_state == S_INV_SQR) && !w_ebit) ||
                   (r_state == S_INV_MUL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = S_INV_SQR;
      end
      S_INV_SQR: begin
        if (w_mend) begin
          if (w_ebit)       w_next = S_INV_MUL;
          else if (w_elast) w_next = S_MUL_X;
        end
      end
      S_INV_MUL: begin
        if (w_mend) w_next = w_elast ? S_MUL_X : S_INV_SQR;
      end
      S_MUL_X: begin
        if (w_mend) w_next = S_MUL_Y;
      end
      S_MUL_Y: begin
        if (w_mend) w_next = S_DONE;
      end
      S_DONE: begin
        if (r_oval && out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_zz   <= 1'b0;
      r_r    <= '0;
      r_acc  <= '0;
      r_bit  <= '0;
      r_eidx <= '0;
      r_oval <= 1'b0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_ozz  <= 1'b0;
    end else if (w_accept) begin
      r_x    <= w_xred;
      r_y    <= w_yred;
      r_z    <= w_zred;
      r_zz   <= (w_zred == '0);
      r_r    <= 256'd1;
      r_acc  <= '0;
      r_bit  <= 8'd255;
      r_eidx <= 8'd254;
    end else if (w_busy) begin
      r_bit <= r_bit - 8'd1;
      if (w_edec) r_eidx <= r_eidx - 8'd1;
      if (w_mend) begin
        r_acc <= '0;
        case (r_state)
          S_MUL_X: r_ox  <= w_step;
          S_MUL_Y: r_acc <= w_step;
          default: r_r   <= w_step;
        endcase
      end else begin
        r_acc <= w_step;
      end
    end else if (r_state == S_DONE) begin
      // Publish the y product one cycle after the final multiply step.
      if (!r_oval) begin
        r_oy   <= r_acc;
        r_ozz  <= r_zz;
        r_oval <= 1'b1;
      end else if (out_ready) begin
        r_oval <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_oval;
  assign out_x     = r_ox;
  assign out_y     = r_oy;
  assign out_enc   = {r_ox[0], r_oy[254:0]};
  assign out_zzero = r_ozz;

endmodule

// File: tb/tb_projective_to_affine.sv
// Bench for projective_to_affine: queue scoreboard against a
// modular-exponentiation reference model.
module tb_projective_to_affine;

  localparam logic [255:0] P   = (256'd1 << 255) - 256'd19;
  localparam longint       LAT = 130561;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_x = '0;
  logic [255:0] in_y = '0;
  logic [255:0] in_z = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_x;
  logic [255:0] out_y;
  logic [255:0] out_enc;
  logic         out_zzero;

  projective_to_affine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_enc   (out_enc),
    .out_zzero (out_zzero)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    logic         zz;
    longint       t;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string n,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a,
                                          input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
    return t[255:0];
  endfunction

  // z^(p-2) by LSB-first square-and-multiply; yields 0 for z == 0 mod p.
  function automatic logic [255:0] inv(input logic [255:0] z);
    logic [255:0] e;
    logic [255:0] base;
    logic [255:0] r;
    e    = P - 256'd2;
    base = z % P;
    r    = 256'd1;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, base);
      base = mulmod(base, base);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model(input  logic [255:0] x,
                       input  logic [255:0] y,
                       input  logic [255:0] z,
                       output exp_t e);
    logic [255:0] zi;
    zi   = inv(z);
    e.x  = mulmod(x, zi);
    e.y  = mulmod(y, zi);
    e.zz = ((z % P) == 256'd0);
    e.t  = 0;
  endtask

  // Monitor: latency on first out_valid, values on handshake.
  logic seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen <= 1'b0;
    end else begin
      if (out_valid && !seen && sb.size() > 0) begin
        seen <= 1'b1;
        chk("latency", 256'(cyc - sb[0].t), 256'(LAT));
      end
      if (out_valid && out_ready) begin
        seen <= 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: x %h", out_x);
        end else begin
          chk("out_x", out_x, sb[0].x);
          chk("out_y", out_y, sb[0].y);
          chk("out_enc", out_enc, {sb[0].x[0], sb[0].y[254:0]});
          chk("out_zzero", 256'(out_zzero), 256'(sb[0].zz));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [255:0] x,
                      input logic [255:0] y,
                      input logic [255:0] z,
                      input bit track);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_x = x;
    in_y = y;
    in_z = z;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %b want 1", in_ready);
    end
    model(x, y, z, e);
    e.t = cyc + 1;
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_drop", 256'(in_ready), 256'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 140000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_x", out_x, 256'd0);
    chk("rst_out_y", out_y, 256'd0);
    chk("rst_out_enc", out_enc, 256'd0);
    chk("rst_out_zzero", 256'(out_zzero), 256'd0);
  endtask

  initial begin
    logic [255:0] sx;
    logic [255:0] sy;
    logic [255:0] se;
    logic         sz;
    bit           stable;
    int           n;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    rst_n = 1'b1;

    // Held result under backpressure.
    out_ready = 1'b0;
    send(256'd7, 256'd9, 256'd1, 1'b1);
    n = 0;
    while (!out_valid && n < 140000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid", 256'(out_valid), 256'd1);
    sx = out_x;
    sy = out_y;
    se = out_enc;
    sz = out_zzero;
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_x !== sx || out_y !== sy || out_enc !== se ||
          out_zzero !== sz || !out_valid || in_ready)
        stable = 1'b0;
    end
    chk("stall_stable", 256'(stable), 256'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 256'(in_ready), 256'd1);
    chk("release_out_valid", 256'(out_valid), 256'd0);
    wait_idle();

    send(256'd3, 256'd5, P - 256'd1, 1'b1);
    wait_idle();

    send(rand256(), rand256(), 256'd0, 1'b1);
    wait_idle();

    send(P + 256'd5, (P << 1) + 256'd1, P + 256'd1, 1'b1);
    wait_idle();

    // Abort a conversion in flight.
    send(256'd7, 256'd9, 256'd1, 1'b0);
    repeat (60000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(256'd7, 256'd9, 256'd1, 1'b1);
    wait_idle();

    send(rand256(), rand256(), rand256(), 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
